// File: rtl/rx_buf_pkg.sv
// Shared types and defaults for the receive hold-back buffer.
package rx_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } holdback_state_t;

  localparam int unsigned RX_WORD_WIDTH_DEFAULT     = 8;
  localparam int unsigned RX_HOLDBACK_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/rx_holdback_out_reg.sv
// Valid/ready output register for forwarded payload words.
// RX_HOLDBACK_OVERRUN_EN adds a sticky flag for words overwritten before acceptance.
module rx_holdback_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_flush,
  input  logic             i_emit,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_emit) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef RX_HOLDBACK_OVERRUN_EN
  logic r_overrun;

  // An emission in the same cycle as acceptance replaces a consumed word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_overrun <= 1'b0;
    end else if (i_flush) begin
      r_overrun <= 1'b0;
    end else if (i_emit && r_valid && !i_ready) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_overrun = r_overrun;
`else
  assign o_overrun = 1'b0;
`endif

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/rx_holdback_buffer.sv
// Delays receive words by DEPTH so the trailing DEPTH words of a packet appear on trailer.
// Overrun detection is built only with RX_HOLDBACK_OVERRUN_EN defined.
module rx_holdback_buffer
  import rx_buf_pkg::*;
#(
  parameter int unsigned WIDTH = RX_WORD_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = RX_HOLDBACK_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       load_buf,
  input  logic                       flush,
  input  logic                       eop,
  input  logic [WIDTH-1:0]           p_out,
  output logic [WIDTH-1:0]           rcv_data,
  output logic                       rcv_valid,
  input  logic                       rcv_ready,
  output logic [DEPTH*WIDTH-1:0]     trailer,
  output logic                       trailer_valid,
  output logic                       short_pkt,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       overrun
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  holdback_state_t r_state, w_state_nxt;

  // Entry 0 is always the oldest word, matching trailer bit ordering.
  logic [DEPTH-1:0][WIDTH-1:0] r_line, w_line_post, w_line_nxt;
  logic [OCC_W-1:0]            r_occ, w_occ_post, w_occ_nxt;
  logic [DEPTH*WIDTH-1:0]      r_trailer;
  logic                        r_trailer_valid, r_short_pkt;
  logic                        w_emit, w_trl_cap, w_short;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The load is applied first; eop then acts on the post-shift contents.
  always_comb begin
    w_line_post = r_line;
    w_occ_post  = r_occ;
    w_emit      = 1'b0;
    if (load_buf) begin
      if (r_state == FULL) begin
        w_emit = 1'b1;
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          w_line_post[i] = r_line[i+1];
        end
        w_line_post[DEPTH-1] = p_out;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (OCC_W'(i) == r_occ) begin
            w_line_post[i] = p_out;
          end
        end
        w_occ_post = r_occ + OCC_W'(1);
      end
    end

    w_line_nxt = w_line_post;
    w_occ_nxt  = w_occ_post;
    w_trl_cap  = 1'b0;
    w_short    = 1'b0;
    if (eop) begin
      w_trl_cap  = (w_occ_post == OCC_FULL);
      w_short    = (w_occ_post != OCC_FULL);
      w_line_nxt = '0;
      w_occ_nxt  = '0;
    end

    if (flush) begin
      w_emit     = 1'b0;
      w_trl_cap  = 1'b0;
      w_short    = 1'b0;
      w_line_nxt = '0;
      w_occ_nxt  = '0;
    end

    if (w_occ_nxt == '0) begin
      w_state_nxt = EMPTY;
    end else if (w_occ_nxt == OCC_FULL) begin
      w_state_nxt = FULL;
    end else begin
      w_state_nxt = FILLING;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_line          <= '0;
      r_occ           <= '0;
      r_trailer       <= '0;
      r_trailer_valid <= 1'b0;
      r_short_pkt     <= 1'b0;
    end else begin
      r_line          <= w_line_nxt;
      r_occ           <= w_occ_nxt;
      r_trailer_valid <= w_trl_cap;
      r_short_pkt     <= w_short;
      if (w_trl_cap) begin
        r_trailer <= w_line_post;
      end
    end
  end

  rx_holdback_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_flush  (flush),
    .i_emit   (w_emit),
    .i_data   (r_line[0]),
    .i_ready  (rcv_ready),
    .o_data   (rcv_data),
    .o_valid  (rcv_valid),
    .o_overrun(overrun)
  );

  assign trailer       = r_trailer;
  assign trailer_valid = r_trailer_valid;
  assign short_pkt     = r_short_pkt;
  assign occupancy     = r_occ;

endmodule
